// File: rtl/uart_pkg.sv
// uart_pkg: byte type and width shared by the UART receiver, transmitter and buffers
package uart_pkg;
  localparam int UART_DATA_W = 8;
  typedef logic [UART_DATA_W-1:0] uart_byte_t;
endpackage

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: DEPTH x byte register array, one write port, one asynchronous read port
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                   i_clk,
  input  logic                   i_we,
  input  logic [AW-1:0]          i_waddr,
  input  logic [UART_DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]          i_raddr,
  output logic [UART_DATA_W-1:0] o_rdata
);
  uart_byte_t mem [DEPTH];
  // storage is deliberately not reset; validity is tracked by the level counter
  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_waddr] <= i_wdata;
  end
  assign o_rdata = mem[i_raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: FWFT byte FIFO behind the UART receiver with sticky overrun; UART_RX_FIFO_DROP_CNT_EN adds o_drop_cnt
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [UART_DATA_W-1:0] i_rx_data,
  input  logic                   i_rx_valid,
  output logic [UART_DATA_W-1:0] o_data,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [CNT_W-1:0]       o_level,
  output logic                   o_full,
  output logic                   o_overrun,
  input  logic                   i_clr_ovr,
  input  logic                   i_flush
`ifdef UART_RX_FIFO_DROP_CNT_EN
  ,
  output logic [7:0]             o_drop_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] level;
  logic overrun, push, pop, drop;
  uart_byte_t rd_data;
  assign o_valid = level != '0;
  assign o_full = level == CNT_W'(DEPTH);
  assign o_level = level;
  assign o_overrun = overrun;
  assign o_data = o_valid ? rd_data : '0;
  assign pop = o_valid && i_ready;
  assign push = i_rx_valid && (!o_full || pop);
  // a flushed strobe is discarded silently, so it never counts as a drop
  assign drop = i_rx_valid && o_full && !pop && !i_flush;
  uart_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .i_clk  (i_clk),
    .i_we   (push && !i_flush),
    .i_waddr(wr_ptr),
    .i_wdata(i_rx_data),
    .i_raddr(rd_ptr),
    .o_rdata(rd_data)
  );
  // pointers and fill level; flush overrides any same-cycle push or pop
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else if (i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      level <= level + CNT_W'(push) - CNT_W'(pop);
    end
  end
  // sticky overrun; a drop in the clearing cycle wins over the clear
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) overrun <= 1'b0;
    else overrun <= drop || (overrun && !i_clr_ovr);
  end
`ifdef UART_RX_FIFO_DROP_CNT_EN
  // saturating dropped-byte count, cleared alongside the overrun flag
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) o_drop_cnt <= '0;
    else if (i_clr_ovr) o_drop_cnt <= {7'd0, drop};
    else if (drop && o_drop_cnt != 8'hFF) o_drop_cnt <= o_drop_cnt + 8'd1;
  end
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed self-checking bench for uart_rx_fifo (DEPTH=16)
module tb_uart_rx_fifo;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] rx_data = '0;
  logic rx_valid = 1'b0;
  logic [7:0] data;
  logic valid;
  logic ready = 1'b0;
  logic [4:0] level;
  logic full;
  logic overrun;
  logic clr_ovr = 1'b0;
  logic flush = 1'b0;
`ifdef UART_RX_FIFO_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif
  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q [16];

  uart_rx_fifo #(.DEPTH(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_data(data), .o_valid(valid), .i_ready(ready), .o_level(level),
    .o_full(full), .o_overrun(overrun), .i_clr_ovr(clr_ovr), .i_flush(flush)
`ifdef UART_RX_FIFO_DROP_CNT_EN
    , .o_drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data = b;
    tick();
    rx_valid = 1'b0;
  endtask

  initial begin
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_valid", valid, 0);
    chk("rst_data", data, 0);
    chk("rst_level", level, 0);
    chk("rst_full", full, 0);
    chk("rst_ovr", overrun, 0);
`ifdef UART_RX_FIFO_DROP_CNT_EN
    chk("rst_dcnt", drop_cnt, 0);
`endif
    tick();
    rx_valid = 1'b1;
    rx_data = 8'hA5;
    #1;
    chk("no_bypass", valid, 0);
    tick();
    rx_valid = 1'b0;
    chk("a5_valid", valid, 1);
    chk("a5_data", data, 8'hA5);
    chk("a5_level", level, 1);
    ready = 1'b1;
    tick();
    chk("pop_valid", valid, 0);
    chk("pop_data", data, 0);
    chk("pop_level", level, 0);
    tick();
    ready = 1'b0;
    chk("empty_rdy_level", level, 0);
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    chk("fill_full", full, 1);
    chk("fill_level", level, 16);
    chk("fill_ovr", overrun, 0);
    chk("fill_head", data, 8'h00);
    push_byte(8'h77);
    chk("drop_ovr", overrun, 1);
    chk("drop_level", level, 16);
    chk("drop_head", data, 8'h00);
`ifdef UART_RX_FIFO_DROP_CNT_EN
    chk("drop_dcnt", drop_cnt, 1);
`endif
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    chk("clr_ovr", overrun, 0);
`ifdef UART_RX_FIFO_DROP_CNT_EN
    chk("clr_dcnt", drop_cnt, 0);
`endif
    ready = 1'b1;
    push_byte(8'h77);
    ready = 1'b0;
    chk("fullpop_level", level, 16);
    chk("fullpop_ovr", overrun, 0);
    chk("fullpop_head", data, 8'h01);
    push_byte(8'h99);
    chk("drop2_ovr", overrun, 1);
    clr_ovr = 1'b1;
    push_byte(8'h99);
    clr_ovr = 1'b0;
    chk("clr_vs_drop_ovr", overrun, 1);
`ifdef UART_RX_FIFO_DROP_CNT_EN
    chk("clr_vs_drop_dcnt", drop_cnt, 1);
`endif
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    chk("clr_alone_ovr", overrun, 0);
    for (int i = 0; i < 15; i++) exp_q[i] = 8'(i + 1);
    exp_q[15] = 8'h77;
    ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain_%0d", i), data, exp_q[i]);
      tick();
    end
    ready = 1'b0;
    chk("drained_valid", valid, 0);
    chk("drained_level", level, 0);
    for (int i = 0; i < 5; i++) push_byte(8'h10 + 8'(i));
    chk("lvl5", level, 5);
    flush = 1'b1;
    ready = 1'b1;
    push_byte(8'h3C);
    flush = 1'b0;
    ready = 1'b0;
    chk("flush_level", level, 0);
    chk("flush_valid", valid, 0);
    chk("flush_data", data, 0);
    chk("flush_ovr", overrun, 0);
    tick();
    chk("flush_stays_empty", valid, 0);
    push_byte(8'h42);
    chk("postflush_data", data, 8'h42);
    chk("postflush_level", level, 1);
    push_byte(8'h43);
    push_byte(8'h44);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", valid, 0);
    chk("arst_data", data, 0);
    chk("arst_level", level, 0);
    rx_valid = 1'b1;
    rx_data = 8'h55;
    tick();
    rx_valid = 1'b0;
    chk("arst_strobe_ignored", level, 0);
    rst_n = 1'b1;
    tick();
    chk("arst_release_valid", valid, 0);
`ifdef UART_RX_FIFO_DROP_CNT_EN
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    rx_valid = 1'b1;
    repeat (260) tick();
    rx_valid = 1'b0;
    chk("dcnt_sat", drop_cnt, 8'hFF);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
